// File: rtl/fifo_arb_pkg.sv
// Shared definitions for the FIFO write-port arbiter and its round-robin finder.
package fifo_arb_pkg;
  localparam int DEF_NUM_REQ    = 4;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_MAX_BURST  = 4;
  localparam int MAX_REQ        = 16;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_e;

  function automatic logic [MAX_REQ-1:0] onehot(input logic [3:0] idx);
    logic [MAX_REQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction
endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin finder: first set request after last_idx, wrapping,
// with last_idx itself considered last.
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_idx,
  output logic               found,
  output logic [IDX_W-1:0]   pick
);
  always_comb begin
    int c;
    c     = 0;
    found = 1'b0;
    pick  = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      c = (int'(last_idx) + i) % NUM_REQ;
      if (!found && req[IDX_W'(c)]) begin
        found = 1'b1;
        pick  = IDX_W'(c);
      end
    end
  end
endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-bounded arbiter sharing one FIFO write port among NUM_REQ
// producers; never writes while the FIFO is full.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ    = DEF_NUM_REQ,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int MAX_BURST  = DEF_MAX_BURST,
  parameter int IDX_W      = $clog2(NUM_REQ),
  parameter int CNT_W      = $clog2(MAX_BURST+1)
) (
  input  logic                          clk_i,
  input  logic                          rst_n_i,
  input  logic [NUM_REQ-1:0]            req_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] data_i,
  output logic [NUM_REQ-1:0]            ack_o,
  output logic [NUM_REQ-1:0]            grant_o,
  input  logic                          fifo_full_i,
  output logic                          fifo_wr_en_o,
  output logic [DATA_WIDTH-1:0]         fifo_wr_data_o,
  output logic                          busy_o
);
  state_e                             state_q, state_d;
  logic [NUM_REQ-1:0]                 grant_d;
  logic [IDX_W-1:0]                   last_q, last_d;
  logic [CNT_W-1:0]                   cnt_q, cnt_d;
  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] data_arr;
  logic                               busy, xfer, end_burst, found;
  logic [IDX_W-1:0]                   pick;

  assign data_arr = data_i;

  // While busy, last_q is the current owner's index.
  assign busy           = (state_q == ST_BURST);
  assign xfer           = busy & req_i[last_q] & ~fifo_full_i;
  assign ack_o          = grant_o & {NUM_REQ{xfer}};
  assign fifo_wr_en_o   = xfer;
  assign fifo_wr_data_o = xfer ? data_arr[last_q] : '0;
  assign busy_o         = busy;
  assign end_burst      = ~req_i[last_q] | (xfer & (cnt_q == CNT_W'(MAX_BURST-1)));

  rr_pick #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_pick (
    .req      (req_i),
    .last_idx (last_q),
    .found    (found),
    .pick     (pick)
  );

  always_comb begin
    state_d = state_q;
    grant_d = grant_o;
    last_d  = last_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (found) begin
          state_d = ST_BURST;
          grant_d = NUM_REQ'(onehot(4'(pick)));
          last_d  = pick;
          cnt_d   = '0;
        end
      end
      ST_BURST: begin
        if (xfer) cnt_d = cnt_q + CNT_W'(1);
        // Regrant without a bubble; the owner is eligible only after everyone else.
        if (end_burst) begin
          cnt_d = '0;
          if (found) begin
            grant_d = NUM_REQ'(onehot(4'(pick)));
            last_d  = pick;
          end else begin
            grant_d = '0;
            state_d = ST_IDLE;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= ST_IDLE;
      grant_o <= '0;
      last_q  <= IDX_W'(NUM_REQ-1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_o <= grant_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Round-robin arbiter that shares the single write port of one FIFO (DEPTH/DATA_WIDTH as in our FIFO blocks) among NUM_REQ producers.
- Grants one producer at a time for a bounded burst and forwards its data to the FIFO write port.
- Never writes while the FIFO reports full, so the FIFO overflow flag can never be raised through this block.
- Sits in the FIFO write-clock domain, directly in front of the FIFO wr_en/wr_data pins.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- DATA_WIDTH, 8, word width; matches the FIFO.
- MAX_BURST, 4, max words per grant before re-arbitration (1..256).
- IDX_W, $clog2(NUM_REQ), requester index width (derived).
- CNT_W, $clog2(MAX_BURST+1), burst counter width (derived).

Ports:
- clk_i  in  1  single clock (FIFO write clock).
- rst_n_i  in  1  reset, asynchronous, active-low.
- req_i  in  NUM_REQ  per-requester "word available"; data valid while high.
- data_i  in  NUM_REQ*DATA_WIDTH  packed words; requester k at [k*DATA_WIDTH +: DATA_WIDTH].
- ack_o  out  NUM_REQ  one-hot; word of requester k accepted this cycle.
- grant_o  out  NUM_REQ  registered one-hot current owner; 0 when idle.
- fifo_full_i  in  1  FIFO full flag.
- fifo_wr_en_o  out  1  FIFO write enable.
- fifo_wr_data_o  out  DATA_WIDTH  FIFO write data.
- busy_o  out  1  high when state is BURST.

Behaviour:
- Reset (async assert, sync release): state=IDLE, grant_o=0, burst_cnt=0, last_idx=NUM_REQ-1 (requester 0 wins first). Combinational outputs ack_o, fifo_wr_en_o, fifo_wr_data_o and busy_o are all 0.
- Transfer condition: xfer = busy & req_i[g] & ~fifo_full_i, where g = grant index.
  - When xfer is high: ack_o[g]=1, fifo_wr_en_o=1, fifo_wr_data_o=data_i[g].
  - When xfer is low: fifo_wr_en_o=0 and fifo_wr_data_o=0.
  - All three are combinational from registered grant.
- Requester handshake: req_i[k] high with data stable; on ack_o[k] the requester presents its next word or drops req. Dropping req with no ack is legal (abort).
- pick = first index with req_i set, searching last_idx+1, +2, ... with wrap modulo NUM_REQ; current owner is eligible last.
- IDLE:
  - If |req_i, then grant_o<=onehot(pick), last_idx<=pick, burst_cnt<=0, go to BURST.
  - Otherwise stay in IDLE.
  - Latency: req seen at edge n, grant_o at n+1, first ack possible in cycle n+1.
- BURST, per cycle:
  - If xfer: burst_cnt<=burst_cnt+1.
  - end_burst = ~req_i[g], or (xfer & burst_cnt==MAX_BURST-1).
  - If end_burst and any req_i (the owner counts only if still requesting): regrant to pick with no bubble cycle, burst_cnt<=0, stay in BURST.
  - If end_burst and no req_i: grant_o<=0, go to IDLE.
  - Otherwise hold grant.
- FIFO full during BURST: grant held, no ack, counter frozen, no timeout. Writes resume the cycle fifo_full_i deasserts.
- Full on the same cycle as owner drop: end_burst on the drop still applies.
- A single requester alone re-wins after MAX_BURST words; grant_o stays constant, counter restarts.
- Arithmetic: burst_cnt is unsigned CNT_W bits and never exceeds MAX_BURST-1 at a compare. last_idx wraps modulo NUM_REQ.
- Reset mid-burst: everything returns to reset values immediately. The partial burst is not resumed; words already acked stay in the FIFO.
- Invariants (bench assertions):
  - $onehot0(grant_o) and $onehot0(ack_o).
  - ack_o is a subset of grant_o.
  - fifo_wr_en_o implies ~fifo_full_i.
  - fifo_wr_en_o equals |ack_o.

Decomposition:
- Shared package fifo_arb_pkg:
  - state encoding ST_IDLE=1'b0, ST_BURST=1'b1.
  - default NUM_REQ, MAX_BURST, DATA_WIDTH constants.
  - function onehot(idx).
- Sub-module rr_pick: combinational round-robin finder; inputs req vector and last_idx, outputs found flag and pick index. Reused by future read-side schedulers.
- Top contains the FSM, burst counter and data mux.

Test Plan:
- Reset then idle: rst_n_i low, req_i=4'b1111 → grant_o=0, ack_o=0, fifo_wr_en_o=0, busy_o=0 throughout. After release with req_i=0 → stays IDLE.
- Single requester: req_i=4'b0001 continuously, data 8'h10..8'h17 → grant_o=0001 one cycle after req. 8 consecutive acks with no bubble at the word-4 boundary. FIFO receives 10..17 in order.
- Full contention: req_i=4'b1111, fifo_full_i=0 → grant sequence 0001 x4 words, 0010 x4, 0100 x4, 1000 x4, then 0001 again. 16 writes in 16 consecutive cycles.
- Backpressure: after 2 words of requester 1, hold fifo_full_i=1 for 5 cycles → ack_o=0 and fifo_wr_en_o=0 for 5 cycles, grant_o=0010 held. Then 2 more words, then grant moves to requester 2.
- Early release: requester 2 drops req_i after 1 word while req_i[3]=1 → next cycle grant_o=1000. Requester 2's burst ends at 1 word.
- Reset mid-burst plus integration: with a 16-deep FIFO, push 20 words from 4 requesters while the reader is stalled → exactly 16 writes, overflow_o never set. Assert rst_n_i mid-burst → grant_o=0 within the same time step.
